reg_dst_queue: RTL
==================

Name: reg_dst_queue

Overview:
- Parametrised successor to the register-destination select mux in the multicycle MIPS datapath.
- Selects the write-back destination from sel: rt, rd, stack pointer or return address.
- Queues up to DEPTH in-flight destinations in issue order and presents the oldest to write-back.
- Flags read-after-write hazards for two source-register queries against all pending destinations.

Parameters:
- REG_ADDR_W, 5, register index width.
- DEPTH, 4, maximum pending destinations (≥2, power of two).
- SP_IDX, 29, index used for sel=2'b10.
- RA_IDX, 31, index used for sel=2'b11.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- sel  in  2  destination selector: 00=rt_field, 01=rd_field, 10=SP_IDX, 11=RA_IDX.
- rt_field  in  REG_ADDR_W  instruction rt field.
- rd_field  in  REG_ADDR_W  instruction rd field.
- issue_valid  in  1  request to enqueue the selected destination.
- issue_ready  out  1  queue can accept; equals !full.
- retire  in  1  write-back of head entry completed; pop.
- wb_dst  out  REG_ADDR_W  head (oldest) destination.
- wb_valid  out  1  queue non-empty.
- src_a  in  REG_ADDR_W  hazard query A.
- src_b  in  REG_ADDR_W  hazard query B.
- hazard_a  out  1  src_a matches any valid entry.
- hazard_b  out  1  src_b matches any valid entry.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- underflow_err  out  1  sticky; set on retire while empty.

Behaviour:
- Reset (reset=0, async): pointers and count = 0; wb_valid=0; wb_dst=0; issue_ready=1; underflow_err=0. Storage contents are don't-care.
- Reset mid-operation discards all pending entries immediately.
- Selection is combinational; the selected index is written at the tail on an accepted issue.
- Accepted issue = issue_valid & issue_ready at the clk edge.
- Pop = retire & wb_valid at the clk edge.
- Latency: an entry issued at edge N is visible on wb_dst/wb_valid and in the hazard compare after edge N.
- wb_dst, wb_valid, hazard_a/b, count and issue_ready all derive from registered state only. There is no combinational path from issue_valid, retire, sel or the field inputs to any output except hazard_a/b (from src_a/b).
- Full (count==DEPTH): issue_ready=0, even if retire is asserted the same cycle (no pass-through); a pending issue waits one cycle.
- Empty:
  - retire is ignored and sets underflow_err.
  - Simultaneous issue+retire: issue accepted, retire ignored, underflow_err set.
- Issue+retire with 0<count<DEPTH: push and pop together; count unchanged.
- Pointers wrap modulo DEPTH.
- Duplicate destinations may be pending; hazard stays asserted until every matching entry retires.
- The hazard compare covers only valid entries; stale slots never match.
- Index widths: the SP_IDX/RA_IDX constants are truncated to REG_ADDR_W.

Optional Feature:
- Macro: REG_DST_ZERO_FILTER_EN.
- Defined:
  - An accepted issue whose selected destination is 0 is consumed (issue_ready semantics unchanged) but not enqueued; count unchanged.
  - hazard_a/b forced 0 when the query is 0.
- Undefined: index 0 is queued and compared like any other register.

Decomposition:
- Shared package/include reg_dst_pkg:
  - localparams SEL_RT=2'b00, SEL_RD=2'b01, SEL_SP=2'b10, SEL_RA=2'b11.
  - defaults SP_IDX_DEF=29, RA_IDX_DEF=31.
- Sub-module reg_dst_fifo (parameters WIDTH, DEPTH):
  - holds storage, pointers, count and full/empty.
  - exposes the entry array and a valid mask for the hazard compare.
- Top level holds the select mux, hazard comparators, underflow flag and the optional zero filter.

Test Plan:
1. Reset release, then issue sel=00 rt=5; sel=01 rd=9; sel=10; sel=11 → wb_dst sequence 5, 9, 29, 31 on successive retires; count 4→0.
2. Fill DEPTH=4, hold issue_valid+retire → issue_ready=0 that cycle; one pop, count=3; the issue is accepted next cycle.
3. Pending {7,7}, src_a=7:
   - first retire → hazard_a stays 1;
   - second retire → hazard_a=0 the cycle after.
4. Empty queue, retire=1 → underflow_err=1 and stays 1; wb_valid=0; count=0.
5. Assert reset low mid-stream with count=3 → outputs at reset values without a clk edge.
6. With REG_DST_ZERO_FILTER_EN: issue rd=0 → count unchanged; src_b=0 → hazard_b=0. Without the macro: count+1 and hazard_b=1.

Source files
------------

// File: rtl/reg_dst_pkg.sv
// reg_dst_pkg: shared constants for the register-destination queue.
//   SEL_*      : encodings of the destination selector
//                (rt field, rd field, stack pointer, return address).
//   *_IDX_DEF  : default register indices for the stack pointer and
//                return address.
package reg_dst_pkg;

    localparam logic [1:0] SEL_RT = 2'b00;
    localparam logic [1:0] SEL_RD = 2'b01;
    localparam logic [1:0] SEL_SP = 2'b10;
    localparam logic [1:0] SEL_RA = 2'b11;

    localparam int SP_IDX_DEF = 29;
    localparam int RA_IDX_DEF = 31;

endpackage

// File: rtl/reg_dst_fifo.sv
// reg_dst_fifo: in-order queue of pending write-back destinations.
// The whole entry array and a per-slot valid mask are exported so the
// parent can compare hazard queries against every pending entry.
// Ports:
//   clk, reset   : rising-edge clock, asynchronous active-low reset
//   push, din    : write din at the tail (caller guarantees !full)
//   pop          : drop the head entry (caller guarantees !empty)
//   head         : oldest entry, forced to 0 while empty
//   entries      : raw storage, one slot per index
//   entry_valid  : 1 for slots currently holding a pending entry
//   count        : number of pending entries
//   full, empty  : occupancy flags derived from count
module reg_dst_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 din,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 head,
    output logic [DEPTH-1:0][WIDTH-1:0]      entries,
    output logic [DEPTH-1:0]                 entry_valid,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full,
    output logic                             empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;

    // Storage holds data only and is not reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = empty ? '0 : mem[rd_ptr];
    assign entries = mem;

    // A slot is pending when its distance from the head is below count,
    // so slots left behind by earlier pops never look valid.
    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [AW-1:0] off;
        assign off            = AW'(i) - rd_ptr;
        assign entry_valid[i] = (CNT_W'(off) < count);
    end

endmodule

// File: rtl/reg_dst_queue.sv
// reg_dst_queue: write-back destination select plus in-flight queue with
// read-after-write hazard detection.
// Optional build macro REG_DST_ZERO_FILTER_EN: issues targeting register 0
// are consumed without being queued, and queries of register 0 never flag
// a hazard. Without it, register 0 behaves like any other register.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   sel                 : 00=rt_field, 01=rd_field, 10=SP_IDX, 11=RA_IDX
//   rt_field, rd_field  : instruction register fields
//   issue_valid         : enqueue request for the selected destination
//   issue_ready         : queue not full
//   retire              : head entry written back, pop it
//   wb_dst, wb_valid    : oldest pending destination / queue non-empty
//   src_a, src_b        : hazard query registers
//   hazard_a, hazard_b  : query matches a pending destination
//   count               : pending entry count
//   underflow_err       : sticky, retire seen while empty
module reg_dst_queue
    import reg_dst_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4,
    parameter int SP_IDX     = SP_IDX_DEF,
    parameter int RA_IDX     = RA_IDX_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   sel,
    input  logic [REG_ADDR_W-1:0]        rt_field,
    input  logic [REG_ADDR_W-1:0]        rd_field,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic                         retire,
    output logic [REG_ADDR_W-1:0]        wb_dst,
    output logic                         wb_valid,
    input  logic [REG_ADDR_W-1:0]        src_a,
    input  logic [REG_ADDR_W-1:0]        src_b,
    output logic                         hazard_a,
    output logic                         hazard_b,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         underflow_err
);

    localparam logic [REG_ADDR_W-1:0] SP_REG = REG_ADDR_W'(SP_IDX);
    localparam logic [REG_ADDR_W-1:0] RA_REG = REG_ADDR_W'(RA_IDX);

    logic [REG_ADDR_W-1:0]             sel_dst;
    logic                              accept;
    logic                              push;
    logic                              pop;
    logic                              full;
    logic                              empty;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  entries;
    logic [DEPTH-1:0]                  entry_valid;
    logic [DEPTH-1:0]                  hit_a;
    logic [DEPTH-1:0]                  hit_b;

    always_comb begin
        sel_dst = rt_field;
        case (sel)
            SEL_RT:  sel_dst = rt_field;
            SEL_RD:  sel_dst = rd_field;
            SEL_SP:  sel_dst = SP_REG;
            default: sel_dst = RA_REG;
        endcase
    end

    // No pass-through when full: a same-cycle retire does not free a slot
    // for the issue, keeping issue_ready purely registered.
    assign issue_ready = !full;
    assign accept      = issue_valid && !full;
    assign pop         = retire && !empty;

`ifdef REG_DST_ZERO_FILTER_EN
    assign push = accept && (sel_dst != '0);
`else
    assign push = accept;
`endif

    reg_dst_fifo #(
        .WIDTH (REG_ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .din         (sel_dst),
        .pop         (pop),
        .head        (wb_dst),
        .entries     (entries),
        .entry_valid (entry_valid),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    assign wb_valid = !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underflow_err <= 1'b0;
        end else if (retire && empty) begin
            underflow_err <= 1'b1;
        end
    end

    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a[i] = entry_valid[i] && (entries[i] == src_a);
            hit_b[i] = entry_valid[i] && (entries[i] == src_b);
        end
    end

`ifdef REG_DST_ZERO_FILTER_EN
    assign hazard_a = (|hit_a) && (src_a != '0);
    assign hazard_b = (|hit_b) && (src_b != '0);
`else
    assign hazard_a = |hit_a;
    assign hazard_b = |hit_b;
`endif

endmodule
